dmem_mmio_unit: RTL and testbench
=================================

// Module: dmem_mmio_unit
// PURPOSE
//  Data-memory stage directly downstream of the single-cycle core: consumes WEmem/Adres_mem/WriteData,
//  returns ReadData combinationally in the same cycle. Holds word RAM plus a small MMIO window with a
//  byte TX FIFO (valid/ready drain), a status register and an error flag for out-of-range stores.
// PARAMETERS
//  DEPTH_WORDS  64             RAM size in 32-bit words; power of 2, >=2
//  FIFO_DEPTH   4              TX FIFO entries; power of 2, >=2
//  MMIO_BASE    32'hFFFF_FF00  MMIO window base; window = 256 bytes, match on Adres_mem[31:8]
// PORTS
//  CLK        in   1   clock, all state on posedge
//  RESET      in   1   reset, synchronous, active-high
//  WEmem      in   1   store strobe from core (sw)
//  Adres_mem  in   32  byte address (ALU result)
//  WriteData  in   32  store data
//  ReadData   out  32  load data, combinational from Adres_mem and current state
//  tx_data    out  8   FIFO head byte
//  tx_valid   out  1   FIFO non-empty
//  tx_ready   in   1   consumer accepts head this cycle
//  addr_err   out  1   sticky: a store hit neither RAM nor MMIO window
// BEHAVIOUR
//  - Decode: MMIO if Adres_mem[31:8]==MMIO_BASE[31:8]; RAM if Adres_mem < DEPTH_WORDS*4; else unmapped.
//    Adres_mem[1:0] ignored everywhere (word access only).
//  - RAM: write at posedge when WEmem & RAM hit; read combinational, new data visible the cycle after the store.
//    RAM contents are not cleared by RESET. Unmapped reads return 0.
//  - MMIO map (offset = Adres_mem[7:0]):
//    0x00 TXDATA  W: push WriteData[7:0]; R: 0
//    0x04 STATUS  R: [0]full [1]empty [2]overflow [15:8]count, rest 0; W: WriteData[2]=1 clears overflow
//    0x08 CYCLES  R: cycle counter (see CONFIGURATION); W: ignored
//    others       R: 0; W: ignored, no addr_err
//  - FIFO: push at posedge if WEmem & TXDATA hit & !full. Pop at posedge if tx_valid & tx_ready.
//    tx_valid = !empty; tx_data = entry at read pointer. Pointers wrap modulo FIFO_DEPTH.
//  - full/empty/count judged on pre-edge state: push while full is dropped even if a pop occurs the same
//    edge, and sets overflow. Push+pop when neither full nor empty: count unchanged, both pointers advance.
//    Pop while empty cannot occur (tx_valid=0).
//  - overflow: set on dropped push, cleared by STATUS write with bit2=1; if set and clear coincide, set wins.
//  - addr_err: set at posedge on WEmem to unmapped address; store dropped; cleared only by RESET.
//  - Reset values: read/write pointers 0, count 0, overflow 0, addr_err 0, CYCLES 0; hence tx_valid=0
//    after the reset edge. RESET mid-transfer discards queued bytes; no pop occurs on the reset edge.
//  - Latency: load 0 cycles (combinational); store/push/clear take effect at the next posedge.
// CONFIGURATION
//  DMEM_CYCLE_COUNTER_EN defined: 32-bit counter, 0 on reset, +1 every non-reset edge, wraps
//    0xFFFF_FFFF->0; read at offset 0x08.
//  Not defined: no counter flops; offset 0x08 reads 0.
// STRUCTURE
//  Shared package dmem_mmio_pkg: MMIO offsets (TXDATA/STATUS/CYCLES), STATUS bit positions, window width.
//  One sub-module: dmem_tx_fifo (storage, pointers, count, full/empty, push/pop); decode, RAM, status,
//  addr_err and counter live in the top.
// TESTING
//  1 RESET; sw 0xDEADBEEF @0x10; next cycle Adres_mem=0x12 -> ReadData=0xDEADBEEF; @0x14 untouched.
//  2 tx_ready=0, push 0x41,0x42 -> tx_valid=1, tx_data=0x41, STATUS=0x0000_0200; tx_ready=1 two cycles
//    -> 0x41 then 0x42 handed off, tx_valid=0, STATUS empty=1.
//  3 FIFO_DEPTH=4, tx_ready=0, push 5 bytes -> 5th dropped, STATUS=0x0000_0405; write STATUS 0x4 -> 0x0000_0401.
//  4 FIFO full, push 0x55 with tx_ready=1 same cycle -> push dropped, count=3, overflow=1, 0x55 never emitted.
//  5 sw @0x0000_1000 (DEPTH_WORDS=64) -> addr_err=1 next cycle, RAM unchanged; stays 1 until RESET.
//  6 Macro on: read 0x08 ten cycles after reset -> 10; macro off -> 0. RESET with 3 bytes queued ->
//    tx_valid=0 and count=0 after the edge.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-memory / MMIO stage: window width, register offsets, STATUS bits.
package dmem_mmio_pkg;

  localparam int MMIO_WIN_BITS = 8;

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CYCLES = 8'h08;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/dmem_tx_fifo.sv
// Byte TX FIFO: circular buffer with read/write pointers and an occupancy count.
module dmem_tx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Full/empty come from pre-edge state, so a push into a full FIFO drops even with a concurrent pop.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_unit.sv
// Data-memory stage: word RAM, MMIO window (TX FIFO, STATUS, CYCLES) and sticky store-address error.
// Optional cycle counter at offset 0x08 is built only when DMEM_CYCLE_COUNTER_EN is defined.
module dmem_mmio_unit
  import dmem_mmio_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WEmem,
  input  logic [31:0] Adres_mem,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        addr_err
);

  localparam int RAM_AW = $clog2(DEPTH_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram [DEPTH_WORDS];
  logic              mmio_hit;
  logic              ram_hit;
  logic [7:0]        offset;
  logic [RAM_AW-1:0] ram_idx;
  logic              tx_push;
  logic              ovf_clr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              overflow;
  logic [31:0]       status_word;
  logic [31:0]       cycle_val;

  assign mmio_hit = (Adres_mem[31:MMIO_WIN_BITS] == MMIO_BASE[31:MMIO_WIN_BITS]);
  assign ram_hit  = ~mmio_hit & (Adres_mem < 32'(DEPTH_WORDS * 4));
  assign offset   = {Adres_mem[7:2], 2'b00};
  assign ram_idx  = Adres_mem[RAM_AW+1:2];

  assign tx_push  = WEmem & mmio_hit & (offset == OFF_TXDATA);
  assign ovf_clr  = WEmem & mmio_hit & (offset == OFF_STATUS) & WriteData[ST_OVF];
  assign tx_valid = ~fifo_empty;

  dmem_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (tx_push),
    .push_data (WriteData[7:0]),
    .pop       (tx_ready),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // RAM has no reset; contents survive RESET.
  always_ff @(posedge CLK) begin
    if (WEmem & ram_hit) ram[ram_idx] <= WriteData;
  end

  // A dropped push and a clear on the same edge leave overflow set.
  always_ff @(posedge CLK) begin
    if (RESET)                       overflow <= 1'b0;
    else if (tx_push & fifo_full)    overflow <= 1'b1;
    else if (ovf_clr)                overflow <= 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET)                            addr_err <= 1'b0;
    else if (WEmem & ~ram_hit & ~mmio_hit) addr_err <= 1'b1;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycles;

  always_ff @(posedge CLK) begin
    if (RESET) cycles <= '0;
    else       cycles <= cycles + 32'd1;
  end

  assign cycle_val = cycles;
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    status_word                           = '0;
    status_word[ST_FULL]                  = fifo_full;
    status_word[ST_EMPTY]                 = fifo_empty;
    status_word[ST_OVF]                   = overflow;
    status_word[ST_COUNT_LSB+7:ST_COUNT_LSB] = 8'(fifo_count);
  end

  always_comb begin
    ReadData = '0;
    if (mmio_hit) begin
      case (offset)
        OFF_STATUS: ReadData = status_word;
        OFF_CYCLES: ReadData = cycle_val;
        default:    ReadData = '0;
      endcase
    end else if (ram_hit) begin
      ReadData = ram[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_mmio_unit.sv
// Scoreboard bench for dmem_mmio_unit: stimulus queues expectations, a negedge monitor checks them.
module tb_dmem_mmio_unit;

  localparam logic [31:0] A_TX  = 32'hFFFF_FF00;
  localparam logic [31:0] A_ST  = 32'hFFFF_FF04;
  localparam logic [31:0] A_CYC = 32'hFFFF_FF08;

  localparam int S_RD  = 0;
  localparam int S_TXV = 1;
  localparam int S_TXD = 2;
  localparam int S_ERR = 3;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        WEmem = 1'b0;
  logic [31:0] Adres_mem = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        addr_err;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t       chk_q[$];
  logic [7:0] tx_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  dmem_mmio_unit dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .WEmem     (WEmem),
    .Adres_mem (Adres_mem),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .addr_err  (addr_err)
  );

  always #5 CLK = ~CLK;

  // Monitor: handoffs are checked against the expected byte stream, register checks against chk_q.
  always @(negedge CLK) begin
    if (!RESET && tx_valid && tx_ready) begin
      n_chk++;
      if (tx_q.size() == 0) begin
        $display("FAIL tx_unexpected got=%02h expected=none", tx_data);
      end else begin
        logic [7:0] e;
        e = tx_q.pop_front();
        if (tx_data === e) n_pass++;
        else $display("FAIL tx_byte got=%02h expected=%02h", tx_data, e);
      end
    end
    while (chk_q.size() > 0) begin
      chk_t c;
      logic [31:0] got;
      c = chk_q.pop_front();
      case (c.sel)
        S_RD:    got = ReadData;
        S_TXV:   got = {31'd0, tx_valid};
        S_TXD:   got = {24'd0, tx_data};
        default: got = {31'd0, addr_err};
      endcase
      n_chk++;
      if (got === c.exp) n_pass++;
      else $display("FAIL %s got=%08h expected=%08h", c.name, got, c.exp);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    WEmem     = we;
    Adres_mem = addr;
    WriteData = wd;
  endtask

  task automatic expect_sig(input int sel, input logic [31:0] val, input string name);
    chk_t c;
    c.sel  = sel;
    c.exp  = val;
    c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit emitted);
    drive(1'b1, A_TX, {24'd0, b});
    if (emitted) tx_q.push_back(b);
    tick();
  endtask

  initial begin
    logic [31:0] cyc_exp;
`ifdef DMEM_CYCLE_COUNTER_EN
    cyc_exp = 32'd10;
`else
    cyc_exp = 32'd0;
`endif

    tick();
    tick();
    RESET = 1'b0;
    drive(1'b0, A_ST, '0);
    expect_sig(S_TXV, 0, "reset_tx_valid");
    expect_sig(S_ERR, 0, "reset_addr_err");
    expect_sig(S_RD, 32'h0000_0002, "reset_status");
    tick();

    // RAM store / load with ignored byte offset
    drive(1'b1, 32'h14, 32'h1234_5678); tick();
    drive(1'b1, 32'h00, 32'h1111_2222); tick();
    drive(1'b1, 32'h10, 32'hDEAD_BEEF); tick();
    drive(1'b0, 32'h12, '0);
    expect_sig(S_RD, 32'hDEAD_BEEF, "ram_rd_0x12");
    tick();
    drive(1'b0, 32'h14, '0);
    expect_sig(S_RD, 32'h1234_5678, "ram_rd_0x14");
    tick();

    // Two bytes queued, then drained
    push_byte(8'h41, 1'b1);
    push_byte(8'h42, 1'b1);
    drive(1'b0, A_ST, '0);
    expect_sig(S_TXV, 1, "tx_valid_2");
    expect_sig(S_TXD, 32'h41, "tx_head_2");
    expect_sig(S_RD, 32'h0000_0200, "status_2");
    tick();
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    expect_sig(S_TXV, 0, "tx_valid_drained");
    expect_sig(S_RD, 32'h0000_0002, "status_drained");
    tick();

    // Overfill: fifth push dropped, then clear overflow
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    push_byte(8'h03, 1'b1);
    push_byte(8'h04, 1'b1);
    push_byte(8'h05, 1'b0);
    drive(1'b0, A_ST, '0);
    expect_sig(S_RD, 32'h0000_0405, "status_overflow");
    tick();
    drive(1'b1, A_ST, 32'h4); tick();
    drive(1'b0, A_ST, '0);
    expect_sig(S_RD, 32'h0000_0401, "status_ovf_cleared");
    tick();

    // Push while full with a concurrent pop: push dropped
    tx_ready = 1'b1;
    push_byte(8'h55, 1'b0);
    tx_ready = 1'b0;
    drive(1'b0, A_ST, '0);
    expect_sig(S_RD, 32'h0000_0304, "status_full_pushpop");
    tick();
    tx_ready = 1'b1;
    tick(); tick(); tick();
    tx_ready = 1'b0;
    expect_sig(S_TXV, 0, "tx_valid_after_drain");
    tick();
    drive(1'b1, A_ST, 32'h4); tick();
    drive(1'b0, A_ST, '0);
    expect_sig(S_RD, 32'h0000_0002, "status_clean");
    tick();

    // MMIO reserved offset and TXDATA read
    drive(1'b1, 32'hFFFF_FF20, 32'hFFFF_FFFF); tick();
    drive(1'b0, A_TX, '0);
    expect_sig(S_ERR, 0, "mmio_reserved_no_err");
    expect_sig(S_RD, 0, "txdata_reads_0");
    tick();

    // Unmapped store
    drive(1'b1, 32'h0000_1000, 32'hCAFE_F00D); tick();
    drive(1'b0, 32'h0, '0);
    expect_sig(S_ERR, 1, "addr_err_set");
    expect_sig(S_RD, 32'h1111_2222, "ram_no_alias");
    tick();
    drive(1'b0, 32'h0000_1000, '0);
    expect_sig(S_RD, 0, "unmapped_rd");
    tick();
    tick();
    tick();
    expect_sig(S_ERR, 1, "addr_err_sticky");
    tick();

    // Reset mid-transfer with tx_ready high; counter after reset
    push_byte(8'hA1, 1'b0);
    push_byte(8'hA2, 1'b0);
    push_byte(8'hA3, 1'b0);
    drive(1'b0, A_ST, '0);
    RESET    = 1'b1;
    tx_ready = 1'b1;
    tick();
    RESET    = 1'b0;
    tx_ready = 1'b0;
    expect_sig(S_TXV, 0, "reset_flush_tx_valid");
    expect_sig(S_RD, 32'h0000_0002, "reset_flush_status");
    expect_sig(S_ERR, 0, "reset_clears_addr_err");
    for (int i = 0; i < 9; i++) tick();
    drive(1'b0, A_CYC, '0);
    tick();
    expect_sig(S_RD, cyc_exp, "cycles_10");
    tick();
    drive(1'b0, 32'h10, '0);
    expect_sig(S_RD, 32'hDEAD_BEEF, "ram_survives_reset");
    tick();
    tick();

    n_chk++;
    if (tx_q.size() == 0 && chk_q.size() == 0) n_pass++;
    else $display("FAIL pending_queues got=%0d/%0d expected=0/0", tx_q.size(), chk_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
